// File: rtl/button_event_decoder.sv
// Turns a debounced button level into single-cycle press / release / long-press /
// auto-repeat events, plus a wrapping 8-bit count of decoded presses.
module button_event_decoder #(
  parameter logic PRESSED_LEVEL = 1'b1,
  parameter int   LONG_TIME     = 100000000,
  parameter int   REPEAT_TIME   = 20000000,
  parameter logic REPEAT_EN     = 1'b1,
  parameter int   CNT_W         = 27
) (
  input  logic       clk_100_MHz,
  input  logic       rst_n,
  input  logic       sig_in,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       long_pulse,
  output logic       repeat_pulse,
  output logic       long_held,
  output logic [7:0] press_cnt
);

  typedef enum logic [1:0] {
    LOCKOUT = 2'd0,
    IDLE    = 2'd1,
    PRESSED = 2'd2,
    REPEAT  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LONG_TC   = CNT_W'(LONG_TIME - 1);
  localparam logic [CNT_W-1:0] REPEAT_TC = CNT_W'(REPEAT_TIME - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             p;

  assign p = (sig_in == PRESSED_LEVEL);

  always_ff @(posedge clk_100_MHz or negedge rst_n) begin
    if (!rst_n) begin
      state         <= LOCKOUT;
      cnt           <= '0;
      press_cnt     <= 8'd0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      long_held     <= 1'b0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      case (state)
        // A button held through reset must be let go before anything is decoded.
        LOCKOUT: begin
          if (!p) state <= IDLE;
        end
        IDLE: begin
          if (p) begin
            state       <= PRESSED;
            cnt         <= '0;
            press_pulse <= 1'b1;
            press_cnt   <= press_cnt + 8'd1;
          end
        end
        // Release wins over a terminal count sampled on the same edge.
        PRESSED: begin
          if (!p) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
          end else if (cnt == LONG_TC) begin
            state      <= REPEAT;
            cnt        <= '0;
            long_pulse <= 1'b1;
            long_held  <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        REPEAT: begin
          if (!p) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            long_held     <= 1'b0;
          end else if (REPEAT_EN && (cnt == REPEAT_TC)) begin
            repeat_pulse <= 1'b1;
            cnt          <= '0;
          end else if (cnt != REPEAT_TC) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state     <= LOCKOUT;
          cnt       <= '0;
          long_held <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with short timing constants
// (LONG_TIME=10, REPEAT_TIME=4); a second instance has auto-repeat disabled.
module tb_button_event_decoder;

  logic       clk_100_MHz = 1'b0;
  logic       rst_n;
  logic       sig_in;
  logic       press_pulse, release_pulse, long_pulse, repeat_pulse, long_held;
  logic [7:0] press_cnt;
  logic       press_pulse2, release_pulse2, long_pulse2, repeat_pulse2, long_held2;
  logic [7:0] press_cnt2;

  int checks = 0;
  int failures = 0;
  int press_tot = 0, release_tot = 0, long_tot = 0, repeat_tot = 0;
  int long2_tot = 0, repeat2_tot = 0;
  int p0, r0, l0, q0, l20, q20;
  logic [7:0] exp_cnt;
  logic [3:0] exp_v;

  always #5 clk_100_MHz = ~clk_100_MHz;

  button_event_decoder #(
    .PRESSED_LEVEL(1'b1), .LONG_TIME(10), .REPEAT_TIME(4), .REPEAT_EN(1'b1), .CNT_W(8)
  ) dut (
    .clk_100_MHz(clk_100_MHz), .rst_n(rst_n), .sig_in(sig_in),
    .press_pulse(press_pulse), .release_pulse(release_pulse),
    .long_pulse(long_pulse), .repeat_pulse(repeat_pulse),
    .long_held(long_held), .press_cnt(press_cnt)
  );

  button_event_decoder #(
    .PRESSED_LEVEL(1'b1), .LONG_TIME(10), .REPEAT_TIME(4), .REPEAT_EN(1'b0), .CNT_W(8)
  ) dut_norep (
    .clk_100_MHz(clk_100_MHz), .rst_n(rst_n), .sig_in(sig_in),
    .press_pulse(press_pulse2), .release_pulse(release_pulse2),
    .long_pulse(long_pulse2), .repeat_pulse(repeat_pulse2),
    .long_held(long_held2), .press_cnt(press_cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock edge; outputs are inspected 1 ns later. Pulse exclusivity is checked every cycle.
  task automatic step();
    @(posedge clk_100_MHz);
    #1;
    chk("onehot_pulses", 32'($onehot0({press_pulse, release_pulse, long_pulse, repeat_pulse})), 32'd1);
    chk("onehot_pulses_norep",
        32'($onehot0({press_pulse2, release_pulse2, long_pulse2, repeat_pulse2})), 32'd1);
    press_tot   += int'(press_pulse);
    release_tot += int'(release_pulse);
    long_tot    += int'(long_pulse);
    repeat_tot  += int'(repeat_pulse);
    long2_tot   += int'(long_pulse2);
    repeat2_tot += int'(repeat_pulse2);
  endtask

  task automatic snap();
    p0 = press_tot; r0 = release_tot; l0 = long_tot; q0 = repeat_tot;
    l20 = long2_tot; q20 = repeat2_tot;
  endtask

  initial begin
    rst_n  = 1'b0;
    sig_in = 1'b0;
    step(); step();
    chk("reset_outputs",
        32'({press_pulse, release_pulse, long_pulse, repeat_pulse, long_held}), 32'd0);
    chk("reset_press_cnt", 32'(press_cnt), 32'd0);
    rst_n = 1'b1;
    step();  // LOCKOUT -> IDLE

    // 1: three-cycle press
    snap();
    sig_in = 1'b1; step();
    chk("t1_press_pulse", 32'(press_pulse), 32'd1);
    chk("t1_press_cnt", 32'(press_cnt), 32'd1);
    step();
    chk("t1_press_single", 32'(press_pulse), 32'd0);
    step();
    sig_in = 1'b0; step();
    chk("t1_release_pulse", 32'(release_pulse), 32'd1);
    step();
    chk("t1_release_single", 32'(release_pulse), 32'd0);
    chk("t1_no_long", 32'(long_tot - l0), 32'd0);
    exp_cnt = 8'd1;

    // 2: 30-cycle hold with long press and auto-repeat
    sig_in = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step();
      exp_v = {k == 0, k == 10, (k > 10) && ((k - 10) % 4 == 0), k >= 10};
      chk("t2_hold_vector", 32'({press_pulse, long_pulse, repeat_pulse, long_held}), 32'(exp_v));
    end
    sig_in = 1'b0; step();
    chk("t2_release", 32'({release_pulse, long_held}), 32'b10);
    exp_cnt = exp_cnt + 8'd1;
    chk("t2_press_cnt", 32'(press_cnt), 32'(exp_cnt));

    // 3: button held through reset deassertion
    rst_n = 1'b0; sig_in = 1'b1;
    step(); step();
    rst_n = 1'b1;
    snap();
    repeat (5) step();
    chk("t3_lockout_no_press", 32'(press_tot - p0), 32'd0);
    chk("t3_lockout_cnt", 32'(press_cnt), 32'd0);
    sig_in = 1'b0; step();
    sig_in = 1'b1; step();
    chk("t3_first_press", 32'({press_pulse, press_cnt}), 32'({1'b1, 8'd1}));
    sig_in = 1'b0; step();
    chk("t3_release", 32'(release_pulse), 32'd1);
    exp_cnt = 8'd1;

    // 4a: release on the edge where PRESSED count is at terminal value
    snap();
    sig_in = 1'b1; step();
    repeat (9) step();
    sig_in = 1'b0; step();
    chk("t4_release_vs_long", 32'({release_pulse, long_pulse, long_held}), 32'b100);
    step();
    chk("t4_no_late_long", 32'(long_tot - l0), 32'd0);
    sig_in = 1'b1; step();
    chk("t4_back_in_idle", 32'(press_pulse), 32'd1);
    sig_in = 1'b0; step();
    exp_cnt = exp_cnt + 8'd2;

    // 4b: release on the edge where REPEAT count is at terminal value
    snap();
    sig_in = 1'b1; step();
    repeat (13) step();
    chk("t4_in_repeat", 32'(long_held), 32'd1);
    sig_in = 1'b0; step();
    chk("t4_release_vs_repeat", 32'({release_pulse, repeat_pulse, long_held}), 32'b100);
    step();
    chk("t4_repeat_counts", 32'({8'(long_tot - l0), 8'(repeat_tot - q0)}), 32'h0100);
    exp_cnt = exp_cnt + 8'd1;
    chk("t4_press_cnt", 32'(press_cnt), 32'(exp_cnt));

    // 5: 257 one-cycle presses wrap the counter
    rst_n = 1'b0; step();
    rst_n = 1'b1; step();
    snap();
    for (int i = 0; i < 257; i++) begin
      sig_in = 1'b1; step();
      sig_in = 1'b0; step();
      if (i == 0) chk("t5_short_release", 32'(release_pulse), 32'd1);
    end
    chk("t5_press_cnt_wrap", 32'(press_cnt), 32'd1);
    chk("t5_press_total", 32'(press_tot - p0), 32'd257);
    chk("t5_release_total", 32'(release_tot - r0), 32'd257);

    // 6: reset asserted mid-REPEAT while the button stays held
    sig_in = 1'b1;
    repeat (16) step();
    chk("t6_held_before", 32'(long_held), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_async_clear",
        32'({press_pulse, release_pulse, long_pulse, repeat_pulse, long_held, press_cnt}), 32'd0);
    chk("t6_async_clear_norep", 32'({long_held2, press_cnt2}), 32'd0);
    step();
    rst_n = 1'b1;
    snap();
    repeat (5) step();
    chk("t6_no_release_after", 32'({8'(release_tot - r0), 8'(press_tot - p0)}), 32'd0);

    // 6b: same 30-cycle hold on both instances, repeat disabled on the second
    sig_in = 1'b0; step();
    snap();
    sig_in = 1'b1;
    repeat (30) step();
    chk("t6_norep_long", 32'(long2_tot - l20), 32'd1);
    chk("t6_norep_no_repeat", 32'(repeat2_tot - q20), 32'd0);
    chk("t6_norep_held", 32'(long_held2), 32'd1);
    chk("t6_rep_count", 32'(repeat_tot - q0), 32'd4);
    sig_in = 1'b0; step();
    chk("t6_norep_release", 32'({release_pulse2, long_held2}), 32'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
